channel_poller_n: RTL

- Parametrised round-robin poller that drains N per-channel acquisition FIFOs into one tagged output stream.
- Sits between the per-channel data_collection FIFOs and the framing/transmit stage.
- Adds three things over the single-channel poller:
  - any channel count;
  - fixed-length bursts with frame markers;
  - a runtime enable mask that only changes between bursts.

---
 rtl/channel_poller_pkg.sv | 20 ++
 rtl/rr_next_ch.sv | 36 +++
 rtl/channel_poller_n.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/channel_poller_pkg.sv
// rtl/channel_poller_pkg.sv - shared types and helpers for the N-channel burst poller
package channel_poller_pkg;

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    WAIT  = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int CH_NONE = 0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_next_ch.sv
// rtl/rr_next_ch.sv - picks the first enabled channel strictly after cur_ch, wrapping
module rr_next_ch
  import channel_poller_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CHW  = 4
) (
  input  logic [N_CH-1:0] i_mask,
  input  logic [CHW-1:0]  i_cur_ch,
  output logic [CHW-1:0]  o_next_ch,
  output logic            o_any_en
);

  logic [CHW:0] w_dist;
  logic [CHW:0] w_best;

  // Distance 1..N_CH after cur_ch; cur_ch itself is farthest so it only wins when alone.
  always_comb begin
    o_next_ch = i_cur_ch;
    w_best    = '1;
    w_dist    = '0;
    for (int j = 0; j < N_CH; j++) begin
      if (CHW'(j) > i_cur_ch)
        w_dist = (CHW+1)'(j) - {1'b0, i_cur_ch};
      else
        w_dist = (CHW+1)'(j + N_CH) - {1'b0, i_cur_ch};
      if (i_mask[j] && (w_dist < w_best)) begin
        w_best    = w_dist;
        o_next_ch = CHW'(j);
      end
    end
  end

  assign o_any_en = |i_mask;

endmodule

// File: rtl/channel_poller_n.sv
// rtl/channel_poller_n.sv - round-robin burst poller draining N channel FIFOs into one tagged stream
module channel_poller_n
  import channel_poller_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int DW        = 16,
  parameter int BURST_LEN = 20,
  parameter int WAIT_CYC  = 100,
  parameter int CHW       = 4
) (
  input  logic                 clk_25m,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  input  logic [N_CH-1:0]      cfg_ch_en,
  input  logic [N_CH-1:0]      fifo_ready,
  input  logic [N_CH*DW-1:0]   fifo_rdata,
  output logic [N_CH-1:0]      rdreq,
  output logic [DW-1:0]        data_out,
  output logic                 data_valid,
  output logic [CHW-1:0]       data_ch,
  output logic                 frame_start,
  output logic                 frame_end,
  output logic                 busy
);

  localparam int WCW = clog2(WAIT_CYC);
  localparam int BCW = clog2(BURST_LEN + 1);

  state_t          r_state, w_next_state;
  logic [N_CH-1:0] r_act_mask, r_pend_mask, w_eff_mask;
  logic            r_pend;
  logic [CHW-1:0]  r_cur_ch, w_next_ch;
  logic            w_any_en;
  logic [WCW-1:0]  r_wait_cnt;
  logic [BCW-1:0]  r_word_cnt;
  logic [N_CH-1:0] w_sel_onehot, w_rdreq_nxt;
  logic [DW-1:0]   w_sel_word;
  logic            w_ready_sel, w_last_word, w_wait_done, w_busy_nxt, w_word_out;

  logic [N_CH-1:0] r_rdreq;
  logic [DW-1:0]   r_data_out;
  logic            r_data_valid, r_frame_start, r_frame_end, r_busy;
  logic [CHW-1:0]  r_data_ch;

  // A pending mask is only consulted in SCAN, so bursts and waits never see a mask change.
  assign w_eff_mask = r_pend ? r_pend_mask : r_act_mask;

  rr_next_ch #(.N_CH(N_CH), .CHW(CHW)) u_rr_next_ch (
    .i_mask    (w_eff_mask),
    .i_cur_ch  (r_cur_ch),
    .o_next_ch (w_next_ch),
    .o_any_en  (w_any_en)
  );

  always_comb begin
    w_sel_onehot = '0;
    w_sel_word   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (r_cur_ch == CHW'(i)) begin
        w_sel_onehot[i] = 1'b1;
        w_sel_word      = fifo_rdata[i*DW +: DW];
      end
    end
  end

  assign w_ready_sel = |(fifo_ready & w_sel_onehot);
  assign w_last_word = (r_word_cnt == BCW'(BURST_LEN - 1));
  assign w_wait_done = (r_wait_cnt == WCW'(WAIT_CYC - 1));
  assign w_word_out  = |r_rdreq;

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= SCAN;
      r_act_mask  <= '0;
      r_pend_mask <= '0;
      r_pend      <= 1'b0;
      r_cur_ch    <= CHW'(N_CH - 1);
      r_wait_cnt  <= '0;
      r_word_cnt  <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == SCAN) begin
        r_act_mask <= w_eff_mask;
        if (w_any_en) r_cur_ch <= w_next_ch;
      end
      if (cfg_valid) begin
        r_pend_mask <= cfg_ch_en;
        r_pend      <= 1'b1;
      end else if (r_state == SCAN) begin
        r_pend <= 1'b0;
      end
      r_wait_cnt <= (r_state == WAIT) ? r_wait_cnt + WCW'(1) : '0;
      r_word_cnt <= (r_state == READ) ? r_word_cnt + BCW'(1) : '0;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      SCAN:    w_next_state = w_any_en ? WAIT : SCAN;
      WAIT: begin
        if (w_ready_sel)      w_next_state = READ;
        else if (w_wait_done) w_next_state = SCAN;
      end
      READ:    w_next_state = w_last_word ? DRAIN : READ;
      DRAIN:   w_next_state = SCAN;
      default: w_next_state = SCAN;
    endcase
  end

  // cur_ch only moves in SCAN, so it is stable for every cycle that can lead into READ.
  always_comb begin
    w_rdreq_nxt = (w_next_state == READ) ? w_sel_onehot : '0;
    w_busy_nxt  = (w_next_state == READ) || (w_next_state == DRAIN);
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      r_rdreq       <= '0;
      r_busy        <= 1'b0;
      r_data_valid  <= 1'b0;
      r_data_out    <= '0;
      r_data_ch     <= CHW'(CH_NONE);
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
    end else begin
      r_rdreq       <= w_rdreq_nxt;
      r_busy        <= w_busy_nxt;
      r_data_valid  <= w_word_out;
      r_data_out    <= w_word_out ? w_sel_word : '0;
      r_data_ch     <= w_word_out ? r_cur_ch + CHW'(1) : CHW'(CH_NONE);
      r_frame_start <= w_word_out && (r_word_cnt == '0);
      r_frame_end   <= w_word_out && w_last_word;
    end
  end

  assign rdreq       = r_rdreq;
  assign busy        = r_busy;
  assign data_valid  = r_data_valid;
  assign data_out    = r_data_out;
  assign data_ch     = r_data_ch;
  assign frame_start = r_frame_start;
  assign frame_end   = r_frame_end;

endmodule
